// File: rtl/fifo_stream_ctrl.sv
// fifo_stream_ctrl: round-robin two-source FIFO writer and FIFO-to-transmitter drain sequencer
//   src0/src1 req/data/ack : byte producers, acked in the cycle their byte is written
//   fifo_we/wdata/full     : FIFO write port
//   fifo_re/rdata/empty    : FIFO read port, rdata valid only while re=1 and not empty
//   drain_en               : permits new transmit frames
//   tx_start/data/busy/done: transmitter handshake
//   busy                   : read sequencer is mid-frame
module fifo_stream_ctrl #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  src0_req,
  input  logic [DATA_WIDTH-1:0] src0_data,
  output logic                  src0_ack,
  input  logic                  src1_req,
  input  logic [DATA_WIDTH-1:0] src1_data,
  output logic                  src1_ack,
  output logic                  fifo_we,
  output logic [DATA_WIDTH-1:0] fifo_wdata,
  input  logic                  fifo_full,
  output logic                  fifo_re,
  input  logic [DATA_WIDTH-1:0] fifo_rdata,
  input  logic                  fifo_empty,
  input  logic                  drain_en,
  output logic                  tx_start,
  output logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_busy,
  input  logic                  tx_done,
  output logic                  busy
);
  typedef enum logic [1:0] {IDLE, START, WAIT} state_t;
  state_t state, state_nxt;
  logic last_grant, grant1, wr_go, pop;
  // Only the outputs are gated by rst; the flops are already held by the async clear.
  always_comb begin
    grant1     = src1_req & (~src0_req | ~last_grant);
    wr_go      = ~fifo_full & (src0_req | src1_req);
    fifo_we    = rst & wr_go;
    src0_ack   = fifo_we & ~grant1;
    src1_ack   = fifo_we & grant1;
    fifo_wdata = fifo_we ? (grant1 ? src1_data : src0_data) : '0;
    pop        = (state == IDLE) & drain_en & ~fifo_empty & ~tx_busy;
    fifo_re    = rst & pop;
    busy       = state != IDLE;
    state_nxt  = pop ? START : (state == START) ? WAIT : (state == WAIT && tx_done) ? IDLE : state;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      tx_start   <= 1'b0;
      tx_data    <= '0;
    end else begin
      state    <= state_nxt;
      tx_start <= pop;
      if (wr_go) last_grant <= grant1;
      if (pop) tx_data <= fifo_rdata;
    end
  end
endmodule
